// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU background fetch path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ppu_pkg;

  // Fetch sequencer states; each VRAM step is an address cycle then a data cycle.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAP_A = 3'd1,
    ST_MAP_D = 3'd2,
    ST_LO_A  = 3'd3,
    ST_LO_D  = 3'd4,
    ST_HI_A  = 3'd5,
    ST_HI_D  = 3'd6,
    ST_PUSH  = 3'd7
  } fetch_state_t;

  // LCDC bit positions used by the background fetcher.
  localparam int LCDC_EN    = 7;
  localparam int LCDC_TDATA = 4;
  localparam int LCDC_BGMAP = 3;
  localparam int LCDC_BGEN  = 0;

  // VRAM offsets (relative to 0x8000).
  localparam logic [12:0] MAP0_BASE         = 13'h1800;
  localparam logic [12:0] MAP1_BASE         = 13'h1C00;
  localparam logic [12:0] TDATA_BASE_SIGNED = 13'h1000;

  // One tile row is 8 pixels wide.
  localparam int PIX_PER_TILE = 8;

  // Address of the low bitplane byte for row 'row' of tile 'idx'.
  // Unsigned mode indexes from 0x0000; signed mode treats idx as -128..127 around 0x1000.
  function automatic logic [12:0] tile_row_addr(input logic [7:0] idx,
                                                input logic       unsigned_sel,
                                                input logic [2:0] row);
    logic [12:0] base;
    if (unsigned_sel) begin
      base = {1'b0, idx, 4'b0000};
    end else begin
      base = TDATA_BASE_SIGNED + {idx[7], idx, 4'b0000};
    end
    return base + {9'b0, row, 1'b0};
  endfunction

endpackage

// File: rtl/ppu_pixel_fifo.sv
// Circular buffer of 2-bit color indices: 8-wide push of a decoded tile row, 1-wide pop.
// Latency: a pushed row is visible at the head the cycle after the push.
// Backpressure: none internally; the writer must only push when count <= DEPTH-8.
module ppu_pixel_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             push,
  input  logic [PIX_PER_TILE-1:0][1:0]     push_dat,
  input  logic                             pop,
  output logic [1:0]                       head,
  output logic [CW-1:0]                    count,
  output logic                             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;

  // Pointer advance with wrap; works for non power-of-two depths since n < DEPTH.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= (PW+1)'(DEPTH)) begin
      s = s - (PW+1)'(DEPTH);
    end
    return s[PW-1:0];
  endfunction

  assign pop_ok = pop && (count_q != '0);
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;
  assign empty  = (count_q == '0);

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        for (int i = 0; i < PIX_PER_TILE; i++) begin
          mem_d[wrap_add(wr_ptr_q, i)] = push_dat[i];
        end
        wr_ptr_d = wrap_add(wr_ptr_q, PIX_PER_TILE);
      end
      if (pop_ok) begin
        rd_ptr_d = wrap_add(rd_ptr_q, 1);
      end
      count_d = count_q + (push ? CW'(PIX_PER_TILE) : CW'(0)) - (pop_ok ? CW'(1) : CW'(0));
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ppu_bg_fetcher.sv
// Walks BG map and tile data for one scanline, decodes 2bpp rows into a pixel FIFO.
// Latency: first tile row reaches the FIFO 7 cycles after start_line (three 2-cycle VRAM reads + push).
// Backpressure: fetch holds in PUSH (no VRAM reads) while the FIFO lacks room for 8 pixels.
module ppu_bg_fetcher
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int LINE_PIXELS = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_line,
  input  logic [7:0]  lcdc,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic [7:0]  ly,
  output logic [12:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_d_rd,
  input  logic        pix_pop,
  output logic        pix_valid,
  output logic [1:0]  pix,
  output logic        line_done
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(LINE_PIXELS + 1);

  fetch_state_t   state_q, state_d;
  logic [4:0]     scx_tile_q, scx_tile_d;
  logic [7:0]     y_q, y_d;
  logic [4:0]     tile_x_q, tile_x_d;
  logic [2:0]     discard_q, discard_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     lo_q, lo_d;
  logic [7:0]     hi_q, hi_d;
  logic [12:0]    row_addr_q, row_addr_d;
  logic           line_done_q, line_done_d;

  logic                          fifo_flush;
  logic                          fifo_push;
  logic                          fifo_pop;
  logic [1:0]                    fifo_head;
  logic [FCW-1:0]                fifo_count;
  logic                          fifo_empty;
  logic [PIX_PER_TILE-1:0][1:0]  push_dat;

  logic        pix_take;
  logic        discard_pop;
  logic [4:0]  tx;
  logic [12:0] map_addr;
  logic [12:0] tile_addr;
  logic        unused_lcdc;

  assign unused_lcdc = ^{lcdc[6:5], lcdc[2:1]};

  // Map column wraps within the 32-tile row; LCDC select bits are used live.
  assign tx          = scx_tile_q + tile_x_q;
  assign map_addr    = (lcdc[LCDC_BGMAP] ? MAP1_BASE : MAP0_BASE) + {3'b000, y_q[7:3], tx};
  assign tile_addr   = tile_row_addr(idx_q, lcdc[LCDC_TDATA], y_q[2:0]);

  // Fine-scroll pixels are dropped internally and never shown to the consumer.
  assign discard_pop = (discard_q != 3'd0) && !fifo_empty;
  assign pix_valid   = !fifo_empty && (discard_q == 3'd0) && (out_cnt_q < OCW'(LINE_PIXELS));
  assign pix_take    = pix_pop && pix_valid;
  assign fifo_pop    = pix_take || discard_pop;
  assign pix         = pix_valid ? fifo_head : 2'b00;
  assign line_done   = line_done_q;

  // Expand the fetched bitplanes into leftmost-first pixels; BG off yields color 0.
  always_comb begin
    push_dat = '0;
    for (int i = 0; i < PIX_PER_TILE; i++) begin
      push_dat[i] = lcdc[LCDC_BGEN] ? {hi_q[7-i], lo_q[7-i]} : 2'b00;
    end
  end

  // Fetch sequencer, VRAM strobes and line bookkeeping.
  always_comb begin
    state_d     = state_q;
    scx_tile_d  = scx_tile_q;
    y_d         = y_q;
    tile_x_d    = tile_x_q;
    discard_d   = discard_q;
    out_cnt_d   = out_cnt_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    row_addr_d  = row_addr_q;
    line_done_d = 1'b0;
    fifo_flush  = 1'b0;
    fifo_push   = 1'b0;
    vram_rd     = 1'b0;
    vram_addr   = '0;

    if (discard_pop) begin
      discard_d = discard_q - 3'd1;
    end
    if (pix_take) begin
      out_cnt_d = out_cnt_q + OCW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_MAP_A: begin
        vram_rd   = 1'b1;
        vram_addr = map_addr;
        state_d   = ST_MAP_D;
      end
      ST_MAP_D: begin
        idx_d   = vram_d_rd;
        state_d = ST_LO_A;
      end
      ST_LO_A: begin
        vram_rd    = 1'b1;
        vram_addr  = tile_addr;
        row_addr_d = tile_addr;
        state_d    = ST_LO_D;
      end
      ST_LO_D: begin
        lo_d    = vram_d_rd;
        state_d = ST_HI_A;
      end
      ST_HI_A: begin
        vram_rd   = 1'b1;
        vram_addr = row_addr_q + 13'd1;
        state_d   = ST_HI_D;
      end
      ST_HI_D: begin
        hi_d    = vram_d_rd;
        state_d = ST_PUSH;
      end
      ST_PUSH: begin
        if (fifo_count <= FCW'(FIFO_DEPTH - PIX_PER_TILE)) begin
          fifo_push = 1'b1;
          tile_x_d  = tile_x_q + 5'd1;
          state_d   = ST_MAP_A;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Last visible pixel taken: end of line, abandon any fetch in flight.
    if (pix_take && (out_cnt_q == OCW'(LINE_PIXELS - 1))) begin
      line_done_d = 1'b1;
      fifo_flush  = 1'b1;
      state_d     = ST_IDLE;
    end

    // LCD switched off mid-line: stop quietly.
    if ((state_q != ST_IDLE) && !lcdc[LCDC_EN]) begin
      fifo_flush = 1'b1;
      state_d    = ST_IDLE;
    end

    // New line (or restart): latch scroll and line, start from the first tile.
    if (start_line && lcdc[LCDC_EN]) begin
      scx_tile_d = scx[7:3];
      y_d        = ly + scy;
      tile_x_d   = 5'd0;
      discard_d  = scx[2:0];
      out_cnt_d  = '0;
      fifo_flush = 1'b1;
      state_d    = ST_MAP_A;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      scx_tile_q  <= '0;
      y_q         <= '0;
      tile_x_q    <= '0;
      discard_q   <= '0;
      out_cnt_q   <= '0;
      idx_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      row_addr_q  <= '0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scx_tile_q  <= scx_tile_d;
      y_q         <= y_d;
      tile_x_q    <= tile_x_d;
      discard_q   <= discard_d;
      out_cnt_q   <= out_cnt_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      row_addr_q  <= row_addr_d;
      line_done_q <= line_done_d;
    end
  end

  ppu_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// Bench for the BG fetcher: VRAM model, pixel/address monitors and a per-pixel reference.
// Inputs driven 2 time units after the rising edge; outputs sampled on the falling edge.
// Pop pressure comes from pop_mode: 0 never, 1 always, 2 random.
module tb_ppu_bg_fetcher;

  localparam int LINE = 160;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_line = 1'b0;
  logic [7:0]  lcdc = 8'h00;
  logic [7:0]  scx = 8'h00;
  logic [7:0]  scy = 8'h00;
  logic [7:0]  ly = 8'h00;
  logic [12:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_d_rd = 8'h00;
  logic        pix_pop = 1'b0;
  logic        pix_valid;
  logic [1:0]  pix;
  logic        line_done;

  logic [7:0]  vram [0:8191];
  logic [12:0] addr_q [$];
  logic [1:0]  pix_q [$];
  int          ld_cnt = 0;
  int          pop_mode = 0;
  int          checks = 0;
  int          errors = 0;

  ppu_bg_fetcher #(
    .FIFO_DEPTH  (16),
    .LINE_PIXELS (LINE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_line (start_line),
    .lcdc       (lcdc),
    .scx        (scx),
    .scy        (scy),
    .ly         (ly),
    .vram_addr  (vram_addr),
    .vram_rd    (vram_rd),
    .vram_d_rd  (vram_d_rd),
    .pix_pop    (pix_pop),
    .pix_valid  (pix_valid),
    .pix        (pix),
    .line_done  (line_done)
  );

  always #5 clk = ~clk;

  // VRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (vram_rd) vram_d_rd <= vram[vram_addr];
  end

  // Consumer pop driver.
  always @(posedge clk) begin
    #2;
    case (pop_mode)
      0:       pix_pop = 1'b0;
      1:       pix_pop = 1'b1;
      default: pix_pop = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitors: VRAM read addresses, accepted pixels, line_done pulses.
  always @(negedge clk) begin
    if (vram_rd) addr_q.push_back(vram_addr);
    if (pix_valid && pix_pop) pix_q.push_back(pix);
    if (line_done) ld_cnt = ld_cnt + 1;
  end

  // Expected color index of visible pixel p, straight from the tile map rules.
  function automatic logic [1:0] ref_pix(input int p, input logic [7:0] l, input logic [7:0] sx,
                                         input logic [7:0] sy, input logic [7:0] yy);
    int y, x, map, idx, base, row;
    logic [7:0] lo, hi;
    y    = (int'(yy) + int'(sy)) % 256;
    x    = (int'(sx) + p) % 256;
    map  = (l[3] ? 'h1C00 : 'h1800) + (y / 8) * 32 + (x / 8);
    idx  = int'(vram[map]);
    if (l[4]) base = idx * 16;
    else      base = 'h1000 + ((idx >= 128) ? idx - 256 : idx) * 16;
    row  = base + (y % 8) * 2;
    lo   = vram[row];
    hi   = vram[row + 1];
    if (!l[0]) return 2'b00;
    return {hi[7 - (x % 8)], lo[7 - (x % 8)]};
  endfunction

  // Index of first pixel differing from the reference; -1 all match, -2 too few pixels.
  function automatic int first_bad(input int pb, input logic [7:0] l, input logic [7:0] sx,
                                   input logic [7:0] sy, input logic [7:0] yy);
    if (pix_q.size() < pb + LINE) return -2;
    for (int i = 0; i < LINE; i++) begin
      if (pix_q[pb + i] !== ref_pix(i, l, sx, sy, yy)) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic init_vram();
    for (int a = 0; a < 8192; a++) vram[a] = 8'($urandom);
  endtask

  task automatic start(input logic [7:0] l, input logic [7:0] sx, input logic [7:0] sy,
                       input logic [7:0] yy, output int pb, output int ab, output int lb);
    tick();
    lcdc = l; scx = sx; scy = sy; ly = yy;
    start_line = 1'b1;
    tick();
    start_line = 1'b0;
    pb = pix_q.size();
    ab = addr_q.size();
    lb = ld_cnt;
  endtask

  task automatic wait_done(input int lb, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (ld_cnt != lb) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (vram_rd !== 1'b0) begin errors++; $display("FAIL reset_vram_rd got %b want 0", vram_rd); end
    checks++; if (vram_addr !== 13'h0) begin errors++; $display("FAIL reset_vram_addr got %h want 0", vram_addr); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
    checks++; if (pix !== 2'b00) begin errors++; $display("FAIL reset_pix got %b want 00", pix); end
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL reset_line_done got %b want 0", line_done); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int pb, ab, lb, fb, bad;
    bit ok;
    logic [12:0] exp_a [3];
    init_vram();
    vram[13'h1800] = 8'h01; vram[13'h0010] = 8'hFF; vram[13'h0011] = 8'h00;
    pop_mode = 1;
    start(8'h91, 8'd0, 8'd0, 8'd0, pb, ab, lb);
    wait_done(lb, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done got timeout want line_done"); end
    exp_a[0] = 13'h1800; exp_a[1] = 13'h0010; exp_a[2] = 13'h0011;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_q[ab + i] !== exp_a[i]) begin
        errors++; $display("FAIL basic_addr%0d got %h want %h", i, addr_q[ab + i], exp_a[i]);
      end
    end
    bad = 0;
    for (int i = 0; i < 8; i++) if (pix_q[pb + i] !== 2'b01) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_first8 got %0d wrong want 0 wrong", bad); end
    fb = first_bad(pb, 8'h91, 8'd0, 8'd0, 8'd0);
    checks++; if (fb !== -1) begin errors++; $display("FAIL basic_line got first bad %0d want -1", fb); end
    checks++; if (pix_q.size() - pb !== LINE) begin errors++; $display("FAIL basic_pops got %0d want %0d", pix_q.size() - pb, LINE); end
    repeat (5) tick();
    checks++; if (ld_cnt - lb !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", ld_cnt - lb); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after got %b want 0", pix_valid); end
  endtask

  task automatic test_signed_tiles();
    int pb, ab, lb, fb;
    bit ok;
    logic [12:0] exp_a [6];
    init_vram();
    vram[13'h1800] = 8'h80; vram[13'h1801] = 8'h00;
    pop_mode = 1;
    start(8'h81, 8'd0, 8'd0, 8'd0, pb, ab, lb);
    wait_done(lb, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL signed_done got timeout want line_done"); end
    exp_a[0] = 13'h1800; exp_a[1] = 13'h0800; exp_a[2] = 13'h0801;
    exp_a[3] = 13'h1801; exp_a[4] = 13'h1000; exp_a[5] = 13'h1001;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (addr_q[ab + i] !== exp_a[i]) begin
        errors++; $display("FAIL signed_addr%0d got %h want %h", i, addr_q[ab + i], exp_a[i]);
      end
    end
    fb = first_bad(pb, 8'h81, 8'd0, 8'd0, 8'd0);
    checks++; if (fb !== -1) begin errors++; $display("FAIL signed_line got first bad %0d want -1", fb); end
  endtask

  task automatic test_scx_discard();
    int pb, ab, lb, fb;
    bit ok;
    init_vram();
    vram[13'h1800] = 8'h00; vram[13'h0000] = 8'h0F; vram[13'h0001] = 8'hF0;
    pop_mode = 2;
    start(8'h91, 8'd3, 8'd0, 8'd0, pb, ab, lb);
    wait_done(lb, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL scx_done got timeout want line_done"); end
    checks++; if (pix_q[pb] !== 2'b10) begin errors++; $display("FAIL scx_pix0 got %b want 10", pix_q[pb]); end
    checks++; if (pix_q[pb + 1] !== 2'b01) begin errors++; $display("FAIL scx_pix1 got %b want 01", pix_q[pb + 1]); end
    fb = first_bad(pb, 8'h91, 8'd3, 8'd0, 8'd0);
    checks++; if (fb !== -1) begin errors++; $display("FAIL scx_line got first bad %0d want -1", fb); end
  endtask

  task automatic test_y_wrap();
    int pb, ab, lb, fb;
    bit ok;
    logic [12:0] exp_t;
    init_vram();
    pop_mode = 1;
    start(8'h91, 8'd0, 8'd1, 8'd255, pb, ab, lb);
    wait_done(lb, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ywrap_done got timeout want line_done"); end
    exp_t = {1'b0, vram[13'h1800], 4'b0000};
    checks++; if (addr_q[ab] !== 13'h1800) begin errors++; $display("FAIL ywrap_map got %h want 1800", addr_q[ab]); end
    checks++; if (addr_q[ab + 1] !== exp_t) begin errors++; $display("FAIL ywrap_row got %h want %h", addr_q[ab + 1], exp_t); end
    fb = first_bad(pb, 8'h91, 8'd0, 8'd1, 8'd255);
    checks++; if (fb !== -1) begin errors++; $display("FAIL ywrap_line got first bad %0d want -1", fb); end
    start(8'h91, 8'd0, 8'd8, 8'd0, pb, ab, lb);
    wait_done(lb, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL scy8_done got timeout want line_done"); end
    checks++; if (addr_q[ab] !== 13'h1820) begin errors++; $display("FAIL scy8_map got %h want 1820", addr_q[ab]); end
    fb = first_bad(pb, 8'h91, 8'd0, 8'd8, 8'd0);
    checks++; if (fb !== -1) begin errors++; $display("FAIL scy8_line got first bad %0d want -1", fb); end
  endtask

  task automatic test_backpressure();
    int pb, ab, lb, fb;
    bit ok;
    logic [7:0] sy, yy;
    init_vram();
    sy = 8'($urandom); yy = 8'($urandom);
    pop_mode = 0;
    start(8'h91, 8'd0, sy, yy, pb, ab, lb);
    repeat (60) tick();
    checks++; if (addr_q.size() - ab !== 9) begin errors++; $display("FAIL bp_reads got %0d want 9", addr_q.size() - ab); end
    checks++; if (vram_rd !== 1'b0) begin errors++; $display("FAIL bp_vram_rd got %b want 0", vram_rd); end
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", pix_valid); end
    pop_mode = 1;
    wait_done(lb, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done got timeout want line_done"); end
    checks++; if (pix_q.size() - pb !== LINE) begin errors++; $display("FAIL bp_pops got %0d want %0d", pix_q.size() - pb, LINE); end
    fb = first_bad(pb, 8'h91, 8'd0, sy, yy);
    checks++; if (fb !== -1) begin errors++; $display("FAIL bp_line got first bad %0d want -1", fb); end
    repeat (5) tick();
    checks++; if (ld_cnt - lb !== 1) begin errors++; $display("FAIL bp_done_pulses got %0d want 1", ld_cnt - lb); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b want 0", pix_valid); end
  endtask

  task automatic test_reset_mid();
    int pb, ab, lb, bad;
    bit ok;
    logic [1:0] line_a [LINE];
    init_vram();
    vram[13'h1800] = 8'h01; vram[13'h0010] = 8'hFF; vram[13'h0011] = 8'h00;
    pop_mode = 1;
    start(8'h91, 8'd0, 8'd0, 8'd0, pb, ab, lb);
    wait_done(lb, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_ref_done got timeout want line_done"); end
    for (int i = 0; i < LINE; i++) line_a[i] = pix_q[pb + i];
    start(8'h91, 8'd0, 8'd0, 8'd0, pb, ab, lb);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    checks++; if (vram_rd !== 1'b0) begin errors++; $display("FAIL rmid_vram_rd got %b want 0", vram_rd); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", pix_valid); end
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL rmid_line_done got %b want 0", line_done); end
    reset = 1'b0;
    start(8'h91, 8'd0, 8'd0, 8'd0, pb, ab, lb);
    wait_done(lb, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_done got timeout want line_done"); end
    bad = 0;
    for (int i = 0; i < LINE; i++) if (pix_q.size() <= pb + i || pix_q[pb + i] !== line_a[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_repeat got %0d differing pixels want 0", bad); end
    checks++; if (addr_q[ab] !== 13'h1800) begin errors++; $display("FAIL rmid_addr0 got %h want 1800", addr_q[ab]); end
  endtask

  task automatic test_lcd_off();
    int pb, ab, lb;
    init_vram();
    pop_mode = 1;
    start(8'h91, 8'd0, 8'd0, 8'd0, pb, ab, lb);
    repeat (30) tick();
    lcdc = 8'h11;
    tick();
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL off_valid got %b want 0", pix_valid); end
    checks++; if (vram_rd !== 1'b0) begin errors++; $display("FAIL off_vram_rd got %b want 0", vram_rd); end
    repeat (300) tick();
    checks++; if (ld_cnt !== lb) begin errors++; $display("FAIL off_no_done got %0d pulses want 0", ld_cnt - lb); end
    lcdc = 8'h91;
  endtask

  task automatic test_restart();
    int pb, ab, lb, fb;
    bit ok;
    logic [7:0] sy, yy;
    init_vram();
    pop_mode = 2;
    start(8'h91, 8'd5, 8'd0, 8'd0, pb, ab, lb);
    repeat (40) tick();
    sy = 8'($urandom); yy = 8'($urandom);
    start(8'h99, 8'd2, sy, yy, pb, ab, lb);
    wait_done(lb, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_done got timeout want line_done"); end
    fb = first_bad(pb, 8'h99, 8'd2, sy, yy);
    checks++; if (fb !== -1) begin errors++; $display("FAIL restart_line got first bad %0d want -1", fb); end
    checks++; if (pix_q.size() - pb !== LINE) begin errors++; $display("FAIL restart_pops got %0d want %0d", pix_q.size() - pb, LINE); end
  endtask

  task automatic test_random_lines();
    int pb, ab, lb, fb;
    bit ok;
    logic [7:0] l, sx, sy, yy;
    for (int n = 0; n < 6; n++) begin
      init_vram();
      l  = 8'h80 | (8'($urandom) & 8'h19);
      sx = 8'($urandom); sy = 8'($urandom); yy = 8'($urandom);
      pop_mode = 1 + (n % 2);
      start(l, sx, sy, yy, pb, ab, lb);
      wait_done(lb, 3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_done got timeout want line_done", n); end
      fb = first_bad(pb, l, sx, sy, yy);
      checks++;
      if (fb !== -1) begin
        errors++;
        $display("FAIL rand%0d_line lcdc=%h scx=%h scy=%h ly=%h got first bad %0d want -1", n, l, sx, sy, yy, fb);
      end
      checks++; if (pix_q.size() - pb !== LINE) begin errors++; $display("FAIL rand%0d_pops got %0d want %0d", n, pix_q.size() - pb, LINE); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_tiles();
    test_scx_discard();
    test_y_wrap();
    test_backpressure();
    test_reset_mid();
    test_lcd_off();
    test_restart();
    test_random_lines();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
